// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the data-cache refill sequencer.
//  - Default geometry: 32-bit addresses, 32-bit beats, 4 beats per 128-bit line.
//  - OFF_W: byte-offset bits inside a line; these are zeroed on mem_addr.
//  - state_t: refill FSM encoding (IDLE, REQ, FILL, UPDATE, DONE, ERR).
//  - idx_width(): counter width for a count of n items, never less than 1 bit.
package cache_ctrl_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int WORD_W_DEF  = 32;
  localparam int BEATS_DEF   = 4;
  localparam int LINE_W_DEF  = WORD_W_DEF * BEATS_DEF;
  localparam int OFF_W       = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    FILL   = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Line-read bus between the refill sequencer and main memory.
//  mem_req    controller -> memory  line-read request, held until mem_ack
//  mem_addr   controller -> memory  line-aligned byte address
//  mem_ack    memory -> controller  request accepted
//  mem_rvalid memory -> controller  mem_rdata carries a beat
//  mem_rdata  memory -> controller  beat data, beat 0 first
// Modports: master = refill controller, slave = memory model/controller.
interface cache_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/refill_line_buf.sv
// Beat assembler for one cache line.
//  clk, reset  clock and async active-high reset (clears the whole line)
//  we          write the beat on din into slot idx
//  idx         beat slot; slot 0 occupies the line LSBs
//  din         WORD_W beat
//  line        LINE_W assembled line; holds its value until overwritten or reset
module refill_line_buf
  import cache_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BEATS  = BEATS_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int IDX_W  = idx_width(BEATS_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] din,
  output logic [LINE_W-1:0] line
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line <= '0;
    end else if (we) begin
      line[idx*WORD_W +: WORD_W] <= din;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer for the data cache.
// Stalls the pipeline on a cache miss during a load/store, reads the missing line
// from memory as BEATS beats, assembles it and hands it to the cache with a
// one-cycle refill_we strobe. A memory that goes silent for TIMEOUT cycles parks
// the controller in a sticky error state until reset.
// Ports:
//  clk, reset          clock, async active-high reset
//  MemRead, MemWrite   pipeline load/store in progress
//  cpu_addr            access address
//  miss                cache miss flag
//  stall               hold the pipeline (combinational)
//  mem                 memory line-read bus (cache_refill_ctrl_if.master)
//  replaceData         assembled line to the cache
//  refill_we           one-cycle cache write strobe
//  bus_err             sticky timeout flag
//  miss_cnt            refills started        (needs REFILL_STATS_EN, else 0)
//  fill_cycles         cycles spent busy      (needs REFILL_STATS_EN, else 0)
// Build option: define REFILL_STATS_EN to build the two statistics counters.
module cache_refill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int BEATS   = BEATS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic                    miss,
  output logic                    stall,
  cache_refill_ctrl_if.master     mem,
  output logic [WORD_W*BEATS-1:0] replaceData,
  output logic                    refill_we,
  output logic                    bus_err,
  output logic [31:0]             miss_cnt,
  output logic [31:0]             fill_cycles
);

  localparam int LINE_W = WORD_W * BEATS;
  localparam int BW     = idx_width(BEATS);
  localparam int TW     = idx_width(TIMEOUT);

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] idle_cnt;
  logic          access;
  logic          mem_evt;
  logic          tmo_hit;
  logic          last_beat;
  logic          beat_we;
  logic          unused_off;

  assign access    = miss & (MemRead | MemWrite);
  // Any memory activity counts as progress for the timeout, whichever state we are in.
  assign mem_evt   = mem.mem_ack | mem.mem_rvalid;
  assign tmo_hit   = ~mem_evt & (idle_cnt == TW'(TIMEOUT - 1));
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign beat_we   = (state == FILL) & mem.mem_rvalid;
  // Byte-offset bits never reach memory; the line address drops them.
  assign unused_off = ^cpu_addr[OFF_W-1:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (access) state_next = REQ;
      REQ: begin
        if (mem.mem_ack)   state_next = FILL;
        else if (tmo_hit)  state_next = ERR;
      end
      FILL: begin
        if (mem.mem_rvalid && last_beat) state_next = UPDATE;
        else if (tmo_hit)                state_next = ERR;
      end
      UPDATE:  state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; mem_req is decoded from the state so reset drops it without waiting for a clock.
  always_comb begin
    stall       = (state != IDLE) | access;
    mem.mem_req = (state == REQ);
    refill_we   = (state == UPDATE);
    bus_err     = (state == ERR);
  end

  // Address latch, beat index and timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.mem_addr <= '0;
      beat_cnt     <= '0;
      idle_cnt     <= '0;
    end else begin
      if (state == IDLE && access) begin
        mem.mem_addr <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
      if (state == REQ && mem.mem_ack) begin
        beat_cnt <= '0;
      end else if (beat_we) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
      if (state == REQ || state == FILL) begin
        idle_cnt <= mem_evt ? '0 : idle_cnt + TW'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  refill_line_buf #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS),
    .LINE_W (LINE_W),
    .IDX_W  (BW)
  ) u_line_buf (
    .clk   (clk),
    .reset (reset),
    .we    (beat_we),
    .idx   (beat_cnt),
    .din   (mem.mem_rdata),
    .line  (replaceData)
  );

`ifdef REFILL_STATS_EN
  logic [31:0] miss_cnt_q;
  logic [31:0] fill_cycles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_cnt_q    <= '0;
      fill_cycles_q <= '0;
    end else begin
      if (state == IDLE && state_next == REQ) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state != IDLE)                      fill_cycles_q <= fill_cycles_q + 32'd1;
    end
  end

  assign miss_cnt    = miss_cnt_q;
  assign fill_cycles = fill_cycles_q;
`else
  assign miss_cnt    = '0;
  assign fill_cycles = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Testbench for cache_refill_ctrl: directed scenarios plus randomized refills,
// checked every cycle against a transaction-level model of the refill protocol.
module tb_cache_refill_ctrl;

  localparam int ADDR_W  = 32;
  localparam int WORD_W  = 32;
  localparam int BEATS   = 4;
  localparam int TIMEOUT = 64;
  localparam int LINE_W  = WORD_W * BEATS;
  localparam logic [LINE_W-1:0] BASIC_LINE = 128'hffff_eeee_dddd_cccc_bbbb_aaaa_9999_8888;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              miss = 1'b0;
  logic              stall;
  logic [LINE_W-1:0] replaceData;
  logic              refill_we;
  logic              bus_err;
  logic [31:0]       miss_cnt;
  logic [31:0]       fill_cycles;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  cache_refill_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) mif ();

  cache_refill_ctrl #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .BEATS(BEATS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .cpu_addr(cpu_addr), .miss(miss), .stall(stall), .mem(mif),
    .replaceData(replaceData), .refill_we(refill_we), .bus_err(bus_err),
    .miss_cnt(miss_cnt), .fill_cycles(fill_cycles)
  );

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding line read described by what has happened so far
  // (request accepted? how many beats received? how many cycles since the last beat?).
  bit                m_active = 0;
  bit                m_acked = 0;
  bit                m_err = 0;
  int                m_got = 0;
  int                m_tail = 0;   // 1: cache-write cycle, 2: release cycle
  int                m_quiet = 0;
  logic [LINE_W-1:0] m_line = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_mcnt = '0;
  logic [31:0]       m_fcyc = '0;

  always @(posedge clk or posedge reset) begin : model
    bit act, ackd, er;
    int got, tail, quiet;
    logic [LINE_W-1:0] ln;
    logic [ADDR_W-1:0] ad;
    logic [31:0] mc, fc;
    if (reset) begin
      m_active <= 0; m_acked <= 0; m_err <= 0; m_got <= 0; m_tail <= 0; m_quiet <= 0;
      m_line <= '0; m_addr <= '0; m_mcnt <= '0; m_fcyc <= '0;
    end else begin
      act = m_active; ackd = m_acked; er = m_err; got = m_got; tail = m_tail;
      quiet = m_quiet; ln = m_line; ad = m_addr; mc = m_mcnt; fc = m_fcyc;
      if (act || er) fc = fc + 32'd1;
      if (er) begin
        // stuck until reset
      end else if (!act) begin
        if (miss && (MemRead || MemWrite)) begin
          act = 1; ackd = 0; got = 0; tail = 0; quiet = 0;
          ad = cpu_addr & ~32'hF;
          mc = mc + 32'd1;
        end
      end else if (tail == 1) begin
        tail = 2;
      end else if (tail == 2) begin
        act = 0; tail = 0;
      end else begin
        if (!ackd) begin
          if (mif.mem_ack) ackd = 1;
        end else if (mif.mem_rvalid) begin
          ln[got*WORD_W +: WORD_W] = mif.mem_rdata;
          got++;
          if (got == BEATS) tail = 1;
        end
        if (mif.mem_ack || mif.mem_rvalid) quiet = 0;
        else begin
          quiet++;
          if (quiet == TIMEOUT) begin er = 1; act = 0; end
        end
      end
      m_active <= act; m_acked <= ackd; m_err <= er; m_got <= got; m_tail <= tail;
      m_quiet <= quiet; m_line <= ln; m_addr <= ad; m_mcnt <= mc; m_fcyc <= fc;
    end
  end

  // Every-cycle comparison, on the falling edge away from the DUT's clock edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", 128'(stall), 128'(m_active || m_err || (miss && (MemRead || MemWrite))));
      chk("mem_req", 128'(mif.mem_req), 128'(m_active && !m_acked));
      chk("refill_we", 128'(refill_we), 128'(m_active && m_tail == 1));
      chk("bus_err", 128'(bus_err), 128'(m_err));
      chk("mem_addr", 128'(mif.mem_addr), 128'(m_addr));
      chk("replaceData", replaceData, m_line);
`ifdef REFILL_STATS_EN
      chk("miss_cnt", 128'(miss_cnt), 128'(m_mcnt));
      chk("fill_cycles", 128'(fill_cycles), 128'(m_fcyc));
`else
      chk("miss_cnt", 128'(miss_cnt), 128'(0));
      chk("fill_cycles", 128'(fill_cycles), 128'(0));
`endif
      if (refill_we) we_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    MemRead = 0; MemWrite = 0; miss = 0; cpu_addr = '0;
    mif.mem_ack = 0; mif.mem_rvalid = 0; mif.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1;
    clear_inputs();
    #4 reset = 0;
  endtask

  // One full refill as seen from the memory side; returns with the controller idle.
  task automatic do_refill(input logic [ADDR_W-1:0] addr, input bit wr, input logic [LINE_W-1:0] ln,
                           input int ack_dly, input bit early, input int gap_at, input int gap_len,
                           input int gmax, input bit extra);
    cpu_addr = addr; MemRead = !wr; MemWrite = wr; miss = 1;
    tick();
    for (int i = 0; i < ack_dly; i++) begin
      mif.mem_rvalid = early && (i == 0);
      mif.mem_rdata  = 32'hDEAD_BEEF;
      tick();
    end
    mif.mem_ack = 1;
    mif.mem_rvalid = early && (ack_dly == 0);
    mif.mem_rdata = 32'hDEAD_BEEF;
    tick();
    mif.mem_ack = 0; mif.mem_rvalid = 0;
    for (int b = 0; b < BEATS; b++) begin
      int g;
      g = (b == gap_at) ? gap_len : ((gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
      repeat (g) tick();
      mif.mem_rvalid = 1;
      mif.mem_rdata = ln[b*WORD_W +: WORD_W];
      tick();
      mif.mem_rvalid = 0;
    end
    miss = 0;
    if (extra) begin
      mif.mem_rvalid = 1;
      mif.mem_rdata = 32'h5A5A_A5A5;
    end
    tick();
    mif.mem_rvalid = 0;
    tick();
    MemRead = 0; MemWrite = 0;
  endtask

  // Cycles that must not start a refill.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      miss = 1'($urandom_range(1, 0));
      MemRead = 1'($urandom_range(1, 0));
      MemWrite = 1'($urandom_range(1, 0));
      if (miss && (MemRead || MemWrite)) miss = 0;
      cpu_addr = $urandom;
      tick();
    end
    miss = 0; MemRead = 0; MemWrite = 0;
  endtask

  initial begin : stim
    int w0;
    logic [LINE_W-1:0] rl;
    clear_inputs();
    #1 reset = 1;
    #3 reset = 0;
    chk("rst_stall", 128'(stall), 128'(0));
    chk("rst_mem_req", 128'(mif.mem_req), 128'(0));
    chk("rst_refill_we", 128'(refill_we), 128'(0));
    chk("rst_bus_err", 128'(bus_err), 128'(0));
    chk("rst_mem_addr", 128'(mif.mem_addr), 128'(0));
    chk("rst_replaceData", replaceData, 128'(0));
    chk("rst_miss_cnt", 128'(miss_cnt), 128'(0));
    chk("rst_fill_cycles", 128'(fill_cycles), 128'(0));
    cmp_en = 1;

    // Basic refill: stall seen in the miss cycle, single strobe, known line.
    tick();
    cpu_addr = 32'h3; MemRead = 1; miss = 1;
    #1 chk("basic_stall_same_cycle", 128'(stall), 128'(1));
    w0 = we_cnt;
    do_refill(32'h3, 0, BASIC_LINE, 2, 0, -1, 0, 0, 0);
    chk("basic_line", replaceData, BASIC_LINE);
    chk("basic_mem_addr", 128'(mif.mem_addr), 128'(0));
    chk("basic_we_pulses", 128'(we_cnt - w0), 128'(1));
    chk("basic_stall_released", 128'(stall), 128'(0));

    // Gapped beats with an early rvalid in REQ and a stray rvalid after the last beat.
    w0 = we_cnt;
    do_refill(32'h1234_5678, 1, BASIC_LINE, 2, 1, 2, 3, 0, 1);
    chk("gap_line", replaceData, BASIC_LINE);
    chk("gap_mem_addr", 128'(mif.mem_addr), 128'(32'h1234_5670));
    chk("gap_we_pulses", 128'(we_cnt - w0), 128'(1));

    // Randomized refills interleaved with non-access cycles.
    for (int n = 0; n < 40; n++) begin
      rl = {$urandom, $urandom, $urandom, $urandom};
      idle_cycles(int'($urandom_range(3, 0)));
      do_refill($urandom, 1'($urandom_range(1, 0)), rl, int'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)), -1, 0, 2, 1'($urandom_range(1, 0)));
      chk("rand_line", replaceData, rl);
    end

    // Reset while requesting drops mem_req without a clock edge.
    do_reset();
    cpu_addr = 32'h40; MemRead = 1; miss = 1;
    tick();
    #1 chk("req_before_reset", 128'(mif.mem_req), 128'(1));
    reset = 1;
    clear_inputs();
    #1 chk("req_async_drop", 128'(mif.mem_req), 128'(0));
    #2 reset = 0;

    // Reset after two beats discards the partial line; a later refill is clean.
    tick();
    cpu_addr = 32'h80; MemRead = 1; miss = 1;
    tick();
    mif.mem_ack = 1;
    tick();
    mif.mem_ack = 0;
    for (int b = 0; b < 2; b++) begin
      mif.mem_rvalid = 1; mif.mem_rdata = 32'h1111_0000 + 32'(b);
      tick();
    end
    reset = 1;
    clear_inputs();
    #1 chk("midfill_mem_req", 128'(mif.mem_req), 128'(0));
    chk("midfill_line_cleared", replaceData, 128'(0));
    chk("midfill_stall", 128'(stall), 128'(0));
    #2 reset = 0;
    tick();
    do_refill(32'h84, 0, BASIC_LINE, 0, 0, -1, 0, 0, 0);
    chk("after_reset_line", replaceData, BASIC_LINE);
    chk("after_reset_addr", 128'(mif.mem_addr), 128'(32'h80));

    // Two back-to-back misses, ack in the request cycle.
    do_reset();
    do_refill(32'h100, 0, BASIC_LINE, 0, 0, -1, 0, 0, 0);
    do_refill(32'h200, 1, ~BASIC_LINE, 0, 0, -1, 0, 0, 0);
`ifdef REFILL_STATS_EN
    chk("stats_miss_cnt", 128'(miss_cnt), 128'(2));
    chk("stats_fill_cycles", 128'(fill_cycles), 128'(14));
`else
    chk("stats_miss_cnt_off", 128'(miss_cnt), 128'(0));
    chk("stats_fill_cycles_off", 128'(fill_cycles), 128'(0));
`endif

    // Timeout: no ack for TIMEOUT cycles in REQ.
    cpu_addr = 32'h300; MemWrite = 1; miss = 1;
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("tmo_not_yet", 128'(bus_err), 128'(0));
    chk("tmo_req_held", 128'(mif.mem_req), 128'(1));
    tick();
    chk("tmo_bus_err", 128'(bus_err), 128'(1));
    chk("tmo_stall", 128'(stall), 128'(1));
    miss = 0; MemWrite = 0;
    repeat (5) tick();
    chk("tmo_bus_err_sticky", 128'(bus_err), 128'(1));
    chk("tmo_stall_sticky", 128'(stall), 128'(1));
    do_reset();
    #1 chk("tmo_cleared", 128'(bus_err), 128'(0));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
